master_trigger_gen: RTL
=======================

Name: master_trigger_gen

Overview:
- Generates the radar master trigger: a periodic pulse train (PRI timer) with programmable period, pulse width and burst length.
- Feeds the master trigger input of the waveform generator stage; that stage's TriggerDelay derives the synth trigger from it.
- Controlled by the register block through one write-register struct and one read-register struct.

Parameters:
- PERIOD_WIDTH, 32, width of period counter and ipPeriod.
- LENGTH_WIDTH, 16, width of ipLength (pulse high time, clocks).
- BURST_WIDTH, 16, width of ipBurstCount and opPulseIndex.

Ports:
- ipClk  in  1  system clock; single clock domain.
- ipReset  in  1  synchronous, active-high reset.
- ipEnable  in  1  level; low aborts any burst and holds block idle.
- ipStart  in  1  single-cycle start strobe; arms a burst.
- ipPeriod  in  PERIOD_WIDTH  trigger period in clocks.
- ipLength  in  LENGTH_WIDTH  trigger high time in clocks.
- ipBurstCount  in  BURST_WIDTH  triggers per burst; 0 = continuous.
- opTrigger  out  1  master trigger pulse train.
- opBusy  out  1  high while state is RUN.
- opPulseIndex  out  BURST_WIDTH  index of the current trigger within the burst, from 0.
- opFrameDone  out  1  one-cycle strobe after the last period of a finite burst.

Behaviour:
- Reset: state IDLE; opTrigger, opBusy, opFrameDone = 0; opPulseIndex = 0; counters = 0. Reset mid-burst aborts immediately, with no opFrameDone.
- FSM states are IDLE and RUN.
- IDLE -> RUN on ipStart=1 && ipEnable=1 in the same cycle.
  - That edge latches Period, Length and BurstCount into shadow registers.
  - Input changes during RUN have no effect until the next start.
- Latency: opTrigger and opBusy go high on the clock edge after the start cycle, i.e. the first observable cycle.
- Period counter PCnt runs 0..P-1, then wraps to 0, starting from 0 in the first RUN cycle.
  - P = max(shadow Period, 2).
- Width: L = clamp(shadow Length, 1, P-1), so there is always at least one low cycle between triggers.
- opTrigger = 1 while RUN and PCnt < L; it is a registered output with no glitches.
- opPulseIndex starts at 0 and increments (registered) on each PCnt wrap. In continuous mode it wraps modulo 2^BURST_WIDTH.
- Finite burst (N = BurstCount > 0):
  - On the wrap that ends the period with index N-1, go to IDLE.
  - opFrameDone = 1 for exactly that one cycle, as opBusy falls.
  - opPulseIndex holds N-1 until the next start.
- Continuous mode (BurstCount = 0): run until ipEnable=0. opFrameDone never asserts.
- ipEnable=0 in RUN: next cycle state = IDLE, opTrigger = 0, opBusy = 0, no opFrameDone. Abort takes precedence over the wrap/done in the same cycle.
- ipStart while RUN is ignored; it does not retrigger or reload.
- ipStart in the same cycle as the finishing wrap is ignored. A new start must arrive while opBusy = 0.
- Counter arithmetic is unsigned. Period = 0 or 1 is treated as 2; Length = 0 is treated as 1.

Decomposition:
- Shared radar register package holds:
  - MASTER_TRIGGER_WR_REGISTERS struct {Enable, Start, Period, Length, BurstCount};
  - MASTER_TRIGGER_RD_REGISTERS struct {Busy, PulseIndex};
  - the default width constants.
- The top level wraps the ports into these structs, in the same style as the waveform generator's register interface.
- No sub-module: a single FSM with period and burst counters (~150 RTL lines).

Test Plan:
- Period=10, Length=3, Burst=4, start -> 4 triggers 3 clocks high, rising edges at cycles 1, 11, 21, 31 after start; opFrameDone at cycle 40; opBusy high for cycles 1-40; opPulseIndex ends at 3.
- Period=1, Length=0, Burst=2 -> P=2, L=1: triggers high at cycles 1 and 3, low at 2 and 4; opFrameDone at cycle 4.
- Period=5, Length=9, Burst=0 -> high 4 clocks, low 1 clock, repeating; drop ipEnable at cycle 23 -> opTrigger and opBusy are 0 at cycle 24; no opFrameDone.
- Mid-burst write of Period=100 and a second ipStart during a Period=8, Burst=3 burst -> original burst unchanged, ending at cycle 24; extra start ignored.
- ipReset asserted during the high phase of pulse 2 -> all outputs 0 on the next cycle; opFrameDone never pulses; a fresh start afterwards behaves as the first test.
- ipStart with ipEnable=0 -> stays IDLE, all outputs 0.

Source files
------------

// File: rtl/master_trigger_gen_pkg.sv
`default_nettype none
// master_trigger_gen_pkg: register structs, state encoding and default widths
// for the radar master trigger generator. Rev 1.0
package master_trigger_gen_pkg;

  localparam int PERIOD_WIDTH_DEFAULT = 32;
  localparam int LENGTH_WIDTH_DEFAULT = 16;
  localparam int BURST_WIDTH_DEFAULT  = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } trig_state_e;

  typedef struct packed {
    logic                            Enable;
    logic                            Start;
    logic [PERIOD_WIDTH_DEFAULT-1:0] Period;
    logic [LENGTH_WIDTH_DEFAULT-1:0] Length;
    logic [BURST_WIDTH_DEFAULT-1:0]  BurstCount;
  } MASTER_TRIGGER_WR_REGISTERS;

  typedef struct packed {
    logic                           Busy;
    logic [BURST_WIDTH_DEFAULT-1:0] PulseIndex;
  } MASTER_TRIGGER_RD_REGISTERS;

endpackage
`default_nettype wire

// File: rtl/master_trigger_gen_if.sv
`default_nettype none
// master_trigger_gen_if: control inputs and trigger outputs of the master
// trigger generator. Rev 1.0
interface master_trigger_gen_if
  import master_trigger_gen_pkg::*;
#(
  parameter int PERIOD_WIDTH = PERIOD_WIDTH_DEFAULT,
  parameter int LENGTH_WIDTH = LENGTH_WIDTH_DEFAULT,
  parameter int BURST_WIDTH  = BURST_WIDTH_DEFAULT
);
  logic                    ipEnable;
  logic                    ipStart;
  logic [PERIOD_WIDTH-1:0] ipPeriod;
  logic [LENGTH_WIDTH-1:0] ipLength;
  logic [BURST_WIDTH-1:0]  ipBurstCount;
  logic                    opTrigger;
  logic                    opBusy;
  logic [BURST_WIDTH-1:0]  opPulseIndex;
  logic                    opFrameDone;

  modport master (
    output ipEnable, ipStart, ipPeriod, ipLength, ipBurstCount,
    input  opTrigger, opBusy, opPulseIndex, opFrameDone
  );

  modport slave (
    input  ipEnable, ipStart, ipPeriod, ipLength, ipBurstCount,
    output opTrigger, opBusy, opPulseIndex, opFrameDone
  );
endinterface
`default_nettype wire

// File: rtl/master_trigger_gen.sv
`default_nettype none
// master_trigger_gen: PRI timer producing a periodic master trigger with
// programmable period, pulse width and burst length. Rev 1.0
module master_trigger_gen
  import master_trigger_gen_pkg::*;
#(
  parameter int PERIOD_WIDTH = PERIOD_WIDTH_DEFAULT,
  parameter int LENGTH_WIDTH = LENGTH_WIDTH_DEFAULT,
  parameter int BURST_WIDTH  = BURST_WIDTH_DEFAULT
) (
  input  wire logic          ipClk,
  input  wire logic          ipReset,
  master_trigger_gen_if.slave bus
);

  MASTER_TRIGGER_WR_REGISTERS wr_regs;
  MASTER_TRIGGER_RD_REGISTERS rd_regs;

  assign wr_regs.Enable     = bus.ipEnable;
  assign wr_regs.Start      = bus.ipStart;
  assign wr_regs.Period     = bus.ipPeriod;
  assign wr_regs.Length     = bus.ipLength;
  assign wr_regs.BurstCount = bus.ipBurstCount;

  trig_state_e             state_q;
  logic [PERIOD_WIDTH-1:0] pcnt_q;
  logic [PERIOD_WIDTH-1:0] plast_q;
  logic [PERIOD_WIDTH-1:0] len_q;
  logic [BURST_WIDTH-1:0]  burst_q;
  logic [BURST_WIDTH-1:0]  idx_q;
  logic                    trig_q;
  logic                    busy_q;
  logic                    done_q;

  logic [PERIOD_WIDTH-1:0] pcnt_d;
  logic [PERIOD_WIDTH-1:0] period_eff_d;
  logic [PERIOD_WIDTH-1:0] length_ext_d;
  logic [PERIOD_WIDTH-1:0] length_eff_d;
  logic                    last_period_d;

  assign pcnt_d        = pcnt_q + PERIOD_WIDTH'(1);
  assign last_period_d = (burst_q != '0) && (idx_q == burst_q - BURST_WIDTH'(1));

  // Width is clamped below the period so at least one low cycle separates triggers.
  always_comb begin
    period_eff_d = (wr_regs.Period < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(2) : wr_regs.Period;
    length_ext_d = PERIOD_WIDTH'(wr_regs.Length);
    length_eff_d = length_ext_d;
    if (length_ext_d == '0) begin
      length_eff_d = PERIOD_WIDTH'(1);
    end else if (length_ext_d >= period_eff_d) begin
      length_eff_d = period_eff_d - PERIOD_WIDTH'(1);
    end
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      plast_q <= '0;
      len_q   <= '0;
      burst_q <= '0;
      idx_q   <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          trig_q <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (wr_regs.Start && wr_regs.Enable) begin
            state_q <= RUN;
            pcnt_q  <= '0;
            idx_q   <= '0;
            plast_q <= period_eff_d - PERIOD_WIDTH'(1);
            len_q   <= length_eff_d;
            burst_q <= wr_regs.BurstCount;
            trig_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          done_q <= 1'b0;
          if (!wr_regs.Enable) begin
            state_q <= IDLE;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (pcnt_q == plast_q) begin
            if (last_period_d) begin
              state_q <= IDLE;
              trig_q  <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              pcnt_q <= '0;
              idx_q  <= idx_q + BURST_WIDTH'(1);
              trig_q <= 1'b1;
            end
          end else begin
            pcnt_q <= pcnt_d;
            trig_q <= (pcnt_d < len_q);
            // Strobe is raised one cycle early so it coincides with the final busy cycle.
            done_q <= (pcnt_d == plast_q) && last_period_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_regs.Busy       = busy_q;
  assign rd_regs.PulseIndex = idx_q;

  assign bus.opTrigger    = trig_q;
  assign bus.opBusy       = rd_regs.Busy;
  assign bus.opPulseIndex = rd_regs.PulseIndex;
  assign bus.opFrameDone  = done_q;

endmodule
`default_nettype wire
